// File: rtl/dual_port_ram_param.sv
// Single-clock true dual-port RAM with a hardware clear sequencer, read-valid strobes,
// selectable cross-port read-during-write behaviour, an optional output stage and write-collision flag.
module dual_port_ram_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] ada,
    input  logic [DATA_W-1:0] ina,
    output logic [DATA_W-1:0] outa,
    output logic              vlda,
    input  logic              enb,
    input  logic              web,
    input  logic [ADDR_W-1:0] adb,
    input  logic [DATA_W-1:0] inb,
    output logic [DATA_W-1:0] outb,
    output logic              vldb,
    output logic              coll
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              coll_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [1:0]        en, we, wr, rd, vld;
    logic [ADDR_W-1:0] ad   [2];
    logic [DATA_W-1:0] din  [2];
    logic [DATA_W-1:0] dout [2];
    logic              ready, same_addr;

    assign en     = {enb, ena};
    assign we     = {web, wea};
    assign ad[0]  = ada;
    assign ad[1]  = adb;
    assign din[0] = ina;
    assign din[1] = inb;

    assign ready     = (state_reg == READY);
    assign same_addr = (ad[0] == ad[1]);
    assign wr        = ready ? (en & we)  : 2'b00;
    assign rd        = ready ? (en & ~we) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
            coll_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            coll_reg  <= wr[0] & wr[1] & same_addr;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            CLEAR: begin
                ptr_next = ptr_reg + ADDR_W'(1);
                if (ptr_reg == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Port A wins a same-address write-write collision.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[ptr_reg] <= '0;
        end else begin
            if (wr[0]) begin
                mem[ad[0]] <= din[0];
            end
            if (wr[1] && !(wr[0] && same_addr)) begin
                mem[ad[1]] <= din[1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam int OTHER = 1 - gi;
            logic [DATA_W-1:0] rdata;
            logic [DATA_W-1:0] s1_reg;
            logic              v1_reg;

            // Write-through forwards the other port's write data on an address match.
            always_comb begin
                rdata = mem[ad[gi]];
                if (RD_MODE == 1 && wr[OTHER] && same_addr) begin
                    rdata = din[OTHER];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg <= '0;
                    v1_reg <= 1'b0;
                end else begin
                    v1_reg <= rd[gi];
                    if (rd[gi]) begin
                        s1_reg <= rdata;
                    end
                end
            end

            if (OUT_REG != 0) begin : g_oreg
                logic [DATA_W-1:0] s2_reg;
                logic              v2_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        s2_reg <= '0;
                        v2_reg <= 1'b0;
                    end else begin
                        v2_reg <= v1_reg;
                        if (v1_reg) begin
                            s2_reg <= s1_reg;
                        end
                    end
                end
                assign dout[gi] = s2_reg;
                assign vld[gi]  = v2_reg;
            end else begin : g_noreg
                assign dout[gi] = s1_reg;
                assign vld[gi]  = v1_reg;
            end
        end
    endgenerate

    assign busy = (state_reg == CLEAR);
    assign coll = coll_reg;
    assign outa = dout[0];
    assign outb = dout[1];
    assign vlda = vld[0];
    assign vldb = vld[1];
endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: u0 = read-first / latency 1, u1 = write-through / latency 2, driven by shared inputs.
module tb_dual_port_ram_param;
    logic       clk = 1'b0;
    logic       rst, clr;
    logic       ena, wea, enb, web;
    logic [2:0] ada, adb;
    logic [7:0] ina, inb;
    logic       busy0, vlda0, vldb0, coll0;
    logic       busy1, vlda1, vldb1, coll1;
    logic [7:0] outa0, outb0, outa1, outb1;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    dual_port_ram_param #(.DATA_W(8), .ADDR_W(3), .RD_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy0),
        .ena(ena), .wea(wea), .ada(ada), .ina(ina), .outa(outa0), .vlda(vlda0),
        .enb(enb), .web(web), .adb(adb), .inb(inb), .outb(outb0), .vldb(vldb0),
        .coll(coll0)
    );

    dual_port_ram_param #(.DATA_W(8), .ADDR_W(3), .RD_MODE(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
        .ena(ena), .wea(wea), .ada(ada), .ina(ina), .outa(outa1), .vlda(vlda1),
        .enb(enb), .web(web), .adb(adb), .inb(inb), .outb(outb1), .vldb(vldb1),
        .coll(coll1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
    endtask

    // Single write on one port; entered and left just after a falling edge.
    task automatic wr(input bit pb, input logic [2:0] a, input logic [7:0] d);
        if (pb) begin enb = 1'b1; web = 1'b1; adb = a; inb = d; end
        else    begin ena = 1'b1; wea = 1'b1; ada = a; ina = d; end
        @(negedge clk);
        idle();
        $display("wr %s addr=%0d data=%02h", pb ? "B" : "A", a, d);
    endtask

    // Single read; u0 result checked after one edge, u1 after two.
    task automatic rd(input bit pb, input logic [2:0] a, input logic [7:0] e0, input logic [7:0] e1);
        if (pb) begin enb = 1'b1; web = 1'b0; adb = a; end
        else    begin ena = 1'b1; wea = 1'b0; ada = a; end
        @(negedge clk);
        idle();
        check("u0 rd data", pb ? outb0 : outa0, e0);
        check("u0 rd vld",  pb ? vldb0 : vlda0, 1);
        check("u1 vld early", pb ? vldb1 : vlda1, 0);
        @(negedge clk);
        check("u1 rd data", pb ? outb1 : outa1, e1);
        check("u1 rd vld",  pb ? vldb1 : vlda1, 1);
        check("u0 vld pulse", pb ? vldb0 : vlda0, 0);
        $display("rd %s addr=%0d u0=%02h u1=%02h", pb ? "B" : "A", a, pb ? outb0 : outa0, pb ? outb1 : outa1);
    endtask

    // Called just after a falling edge with zero clear edges done.
    task automatic busy_run();
        check("busy start", busy0, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("busy u0", busy0, (k < 8) ? 1 : 0);
            check("busy u1", busy1, (k < 8) ? 1 : 0);
        end
        $display("clear sequence ended");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; ada = '0; adb = '0; ina = '0; inb = '0;
        idle();
        repeat (3) @(negedge clk);
        check("rst outa", outa0, 0);
        check("rst vlda", vlda0, 0);
        check("rst coll", coll0, 0);
        check("rst busy", busy0, 1);
        check("rst outb1", outb1, 0);
        rst = 1'b0;
        busy_run();

        // Test 1: cleared contents
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = 3'(i);
            rd(i[0], a, 8'h00, 8'h00);
        end

        // Test 2: write A, then read B
        wr(0, 3'd3, 8'h5A);
        rd(1, 3'd3, 8'h5A, 8'h5A);

        // Test 3: cross-port read during write
        wr(0, 3'd2, 8'h11);
        ena = 1'b1; wea = 1'b1; ada = 3'd2; ina = 8'h22;
        enb = 1'b1; web = 1'b0; adb = 3'd2;
        @(negedge clk);
        idle();
        check("rdw u0 old data", outb0, 8'h11);
        check("rdw u0 vldb", vldb0, 1);
        @(negedge clk);
        check("rdw u1 new data", outb1, 8'h22);
        check("rdw u1 vldb", vldb1, 1);
        $display("rdw addr=2 u0=%02h u1=%02h", outb0, outb1);
        rd(0, 3'd2, 8'h22, 8'h22);

        // Test 4: write-write collision and non-collision
        ena = 1'b1; wea = 1'b1; ada = 3'd6; ina = 8'hAA;
        enb = 1'b1; web = 1'b1; adb = 3'd6; inb = 8'h55;
        @(negedge clk);
        idle();
        check("coll u0 pulse", coll0, 1);
        check("coll u1 pulse", coll1, 1);
        check("no vld on write", vlda0, 0);
        @(negedge clk);
        check("coll u0 end", coll0, 0);
        $display("ww collision addr=6 A=aa B=55");
        rd(1, 3'd6, 8'hAA, 8'hAA);
        ena = 1'b1; wea = 1'b1; ada = 3'd1; ina = 8'h31;
        enb = 1'b1; web = 1'b1; adb = 3'd4; inb = 8'h64;
        @(negedge clk);
        idle();
        check("no coll diff addr", coll0, 0);
        $display("ww addr=1/4 no collision");
        rd(0, 3'd1, 8'h31, 8'h31);
        rd(1, 3'd4, 8'h64, 8'h64);

        // Test 5: fill, clear request with same-edge read, requests ignored while busy
        for (int i = 0; i < 8; i++) wr(i[0], 3'(i), 8'hFF);
        clr = 1'b1; ena = 1'b1; wea = 1'b0; ada = 3'd0;
        @(negedge clk);
        clr = 1'b0;
        check("clr read data", outa0, 8'hFF);
        check("clr read vld", vlda0, 1);
        check("clr busy", busy0, 1);
        ena = 1'b1; wea = 1'b0; ada = 3'd5;
        enb = 1'b1; web = 1'b1; adb = 3'd0; inb = 8'h33;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("clr busy u0", busy0, (c < 8) ? 1 : 0);
            check("clr vlda u0", vlda0, 0);
            check("clr vlda u1", vlda1, (c == 1) ? 1 : 0);
            check("clr vldb u1", vldb1, 0);
            if (c == 1) check("clr read u1", outa1, 8'hFF);
        end
        check("hold outa u0", outa0, 8'hFF);
        idle();
        $display("clr with busy requests done");
        for (int i = 0; i < 8; i++) rd(i[0], 3'(i), 8'h00, 8'h00);

        // Test 6: reset in the middle of a clear
        wr(1, 3'd3, 8'h77);
        rd(0, 3'd3, 8'h77, 8'h77);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        check("mid clr busy", busy0, 1);
        rst = 1'b1;
        #1;
        check("async rst outa u0", outa0, 0);
        check("async rst outa u1", outa1, 0);
        check("async rst busy", busy0, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset during clear");
        busy_run();
        rd(0, 3'd3, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised, single-clock, true dual-port RAM. It succeeds the fixed 8x8 two-clock dual-port RAM. Each of ports A and B independently performs one read or one write per cycle. New behaviour over the previous generation:
- hardware clear sequencer after reset or on request
- read-valid strobes
- selectable cross-port read-during-write semantics
- optional output register stage
- write-write collision detection

The block sits as the shared buffer between two datapath agents in the same clock domain.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 3, address width in bits; DEPTH = 2**ADDR_W words
RD_MODE, 0, cross-port same-address read-during-write: 0 = old data (read-first), 1 = new data (write-through)
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous request to re-zero the whole array
busy  output  1  high while the clear sequence runs; port requests ignored
ena  input  1  port A enable
wea  input  1  port A write (1) / read (0), qualified by ena
ada  input  ADDR_W  port A address
ina  input  DATA_W  port A write data
outa  output  DATA_W  port A read data
vlda  output  1  port A read-data valid, one-cycle pulse per read
enb  input  1  port B enable
web  input  1  port B write / read, qualified by enb
adb  input  ADDR_W  port B address
inb  input  DATA_W  port B write data
outb  output  DATA_W  port B read data
vldb  output  1  port B read-data valid
coll  output  1  one-cycle pulse: write-write collision occurred

Behaviour:
- Reset (asynchronous, rst=1):
  - outa=0, outb=0, vlda=0, vldb=0, coll=0, busy=1.
  - FSM enters CLEAR with clear pointer ptr=0.
  - Memory array is not asynchronously reset.
- FSM states: CLEAR, READY.
- CLEAR state:
  - Each edge writes 0 to mem[ptr], then ptr increments.
  - On the edge that writes ptr=DEPTH-1: go to READY and set busy=0.
  - After rst release, busy is high for exactly DEPTH edges.
- CLEAR input handling:
  - Port requests (ena/enb) are ignored: no write, no read, vld stays 0.
  - outa/outb hold their values.
  - clr is ignored.
- READY state, clr=1 on an edge:
  - Port requests on that same edge are still served.
  - FSM goes to CLEAR with ptr=0 and busy=1 from that edge.
- Reset asserted mid-CLEAR: the sequence restarts from ptr=0 after release.
- Port X (A or B) in READY:
  - Write (enX=1, weX=1): mem[adX] <= inX at the edge.
  - Read (enX=1, weX=0): data is captured at the edge.
    - OUT_REG=0: outX updates and vldX=1 for the cycle following the edge.
    - OUT_REG=1: a second register adds one cycle; vldX pulses one cycle later, aligned with outX.
  - outX holds its last value when no read completes; vldX is 0 otherwise.
- Same port: a write produces no read data, so vldX stays 0.
- Cross-port read/write to the same address in the same cycle:
  - RD_MODE=0: the reader gets the pre-write contents.
  - RD_MODE=1: the reader gets the writer's input data.
- Both ports write the same address in the same cycle:
  - Port A data is stored.
  - coll=1 for the cycle after the edge.
  - No coll pulse for different addresses or read/read.
- Both ports read the same address: both get the same data; no collision.
- Address range is full 2**ADDR_W, so no out-of-range case exists.

Test Plan:
1. Reset, DATA_W=8, ADDR_W=3 -> after rst release, busy=1 for exactly 8 edges then 0; reads of addresses 0..7 all return 0x00 with vld pulses.
2. A writes 0x5A to addr 3; next cycle B reads addr 3 -> outb=0x5A with vldb=1 one cycle after the read edge (OUT_REG=0) / two cycles after (OUT_REG=1).
3. mem[2]=0x11; same edge A writes 0x22 to addr 2 while B reads addr 2 -> outb=0x11 with RD_MODE=0, outb=0x22 with RD_MODE=1; mem[2]=0x22 afterwards in both modes.
4. A writes 0xAA and B writes 0x55 to addr 6 on the same edge -> coll pulses for 1 cycle; read of addr 6 returns 0xAA. A to addr 1 and B to addr 4 on the same edge -> coll stays 0.
5. Fill mem with 0xFF, pulse clr with A reading addr 0 on the same edge -> that read completes (0xFF, vlda=1). busy=1 for 8 edges; requests during busy produce no vld and no writes; afterwards all addresses read 0x00.
6. Assert rst at ptr=4 during CLEAR -> outputs zero immediately; after release, busy lasts a full 8 edges.
